// File: rtl/audio_capture_ctrl.sv
// audio_capture_ctrl: arms on command, waits for an immediate or threshold
// trigger, then streams a bounded number of mic samples into the sample RAM
// through a one-entry valid/ready write stage.
module audio_capture_ctrl #(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                trig_mode_i,
  input  logic [SAMPLE_W-1:0] threshold_i,
  input  logic [COUNT_W-1:0]  capture_len_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic [31:0]         ram_write_data_o,
  output logic                ram_write_valid_o,
  input  logic                ram_write_ready_i,
  input  logic                ram_overflow_i,
  output logic [2:0]          state_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [COUNT_W-1:0]  sample_count_o,
  output logic [COUNT_W-1:0]  drop_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [COUNT_W-1:0]   cfg_len_q;
  logic                 cfg_mode_q;
  logic [SAMPLE_W-1:0]  cfg_thr_q;
  logic [COUNT_W-1:0]   issued_q;

  logic [SAMPLE_W-1:0]  mag_c;
  logic [31:0]          ext_c;
  logic                 trig_hit_c;
  logic                 xfer_c;
  logic                 room_c;
  logic                 in_cap_c;
  logic                 load_c;
  logic                 drop_c;
  logic                 last_c;
  logic                 can_start_c;

  assign state_o = state_q;

  // Unsigned magnitude; the most negative sample maps to 2^(SAMPLE_W-1) without wrapping.
  always_comb begin
    mag_c = sample_i;
    if (sample_i[SAMPLE_W-1]) begin
      mag_c = (~sample_i) + SAMPLE_W'(1);
    end
  end

  // Sign extension of the incoming sample to the RAM word.
  assign ext_c = 32'($signed(sample_i));

  // Shared qualifiers for the write stage and sequencing.
  always_comb begin
    trig_hit_c  = sample_valid_i && (!cfg_mode_q || (mag_c >= cfg_thr_q));
    xfer_c      = ram_write_valid_o && ram_write_ready_i;
    room_c      = issued_q < cfg_len_q;
    in_cap_c    = state_q == ST_CAPTURE;
    load_c      = in_cap_c && sample_valid_i && room_c && (!ram_write_valid_o || xfer_c);
    drop_c      = in_cap_c && sample_valid_i && room_c && ram_write_valid_o && !xfer_c;
    last_c      = in_cap_c && xfer_c && (sample_count_o == (cfg_len_q - COUNT_W'(1)));
    can_start_c = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERROR));
  end

  // Next-state selection; abort wins over overflow and start.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (can_start_c) begin
            state_d = (capture_len_i == '0) ? ST_ERROR : ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (ram_overflow_i) begin
            state_d = ST_ERROR;
          end else if (trig_hit_c) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (ram_overflow_i) begin
            state_d = ST_ERROR;
          end else if (last_c) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, configuration, write stage, counters and status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= ST_IDLE;
      cfg_len_q         <= '0;
      cfg_mode_q        <= 1'b0;
      cfg_thr_q         <= '0;
      issued_q          <= '0;
      ram_write_valid_o <= 1'b0;
      ram_write_data_o  <= '0;
      sample_count_o    <= '0;
      drop_count_o      <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
      done_o  <= state_d == ST_DONE;
      error_o <= state_d == ST_ERROR;

      if (abort_i) begin
        ram_write_valid_o <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (can_start_c) begin
              cfg_len_q         <= capture_len_i;
              cfg_mode_q        <= trig_mode_i;
              cfg_thr_q         <= threshold_i;
              issued_q          <= '0;
              sample_count_o    <= '0;
              drop_count_o      <= '0;
              ram_write_valid_o <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (ram_overflow_i) begin
              ram_write_valid_o <= 1'b0;
            end else if (trig_hit_c) begin
              ram_write_valid_o <= 1'b1;
              ram_write_data_o  <= ext_c;
              issued_q          <= COUNT_W'(1);
            end
          end
          ST_CAPTURE: begin
            if (xfer_c) begin
              sample_count_o <= sample_count_o + COUNT_W'(1);
            end
            if (ram_overflow_i) begin
              ram_write_valid_o <= 1'b0;
            end else begin
              if (load_c) begin
                ram_write_valid_o <= 1'b1;
                ram_write_data_o  <= ext_c;
                issued_q          <= issued_q + COUNT_W'(1);
              end else if (xfer_c) begin
                ram_write_valid_o <= 1'b0;
              end
              if (drop_c && (drop_count_o != '1)) begin
                drop_count_o <= drop_count_o + COUNT_W'(1);
              end
            end
          end
          default: ram_write_valid_o <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/audio_capture_ctrl.md
# audio_capture_ctrl

Sequencer between the I2S capture block and the sample RAM, replacing the free-running write connection. It arms on command and waits for an immediate or threshold trigger. It then streams exactly N samples into the RAM write port through a one-entry valid/ready stage, and reports completion, dropped samples and overflow. A host or debug FSM uses it to take bounded, trigger-aligned recordings of mic channel 0.

## Interface
Parameters:
- SAMPLE_W, 24, width of signed input sample
- COUNT_W, 16, width of length and count fields

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  single-cycle pulse; arm a capture (latches capture_len_i, trig_mode_i, threshold_i)
- abort_i  in  1  single-cycle pulse; return to IDLE
- trig_mode_i  in  1  0 = immediate, 1 = threshold
- threshold_i  in  SAMPLE_W  unsigned magnitude threshold
- capture_len_i  in  COUNT_W  number of samples to record
- sample_i  in  SAMPLE_W  signed sample from I2S capture
- sample_valid_i  in  1  single-cycle strobe per new sample
- ram_write_data_o  out  32  sample sign-extended to 32 bits
- ram_write_valid_o  out  1  write request to RAM
- ram_write_ready_i  in  1  RAM accepts write when high with valid
- ram_overflow_i  in  1  RAM overflow flag
- state_o  out  3  IDLE=0, ARMED=1, CAPTURE=2, DONE=3, ERROR=4
- busy_o  out  1  state is ARMED or CAPTURE
- done_o  out  1  state is DONE
- error_o  out  1  state is ERROR
- sample_count_o  out  COUNT_W  samples accepted by RAM in current capture
- drop_count_o  out  COUNT_W  samples lost because the write stage was occupied; saturates at all-ones

## Operation
- **Reset (rst_ni low at clock edge):**
  - Every output is 0; state is IDLE.
  - The latched configuration is cleared.
- **IDLE:**
  - start_i latches configuration and clears both counters.
  - If the latched length is 0, next state is ERROR. Otherwise next state is ARMED.
- **ARMED:** each sample_valid_i is tested.
  - Immediate mode fires on the first valid sample.
  - Threshold mode fires when |sample_i| >= latched threshold.
  - Magnitude is computed as SAMPLE_W-bit unsigned; |-2^(SAMPLE_W-1)| = 2^(SAMPLE_W-1), with no overflow.
  - The triggering sample is the first sample captured. Next state is CAPTURE.
- **CAPTURE:** every sample_valid_i is loaded into the write stage while issued < len.
  - Loading a sample sets ram_write_valid_o and ram_write_data_o.
  - Samples arriving after issued == len are ignored and not counted as drops.
- **Write stage:**
  - A transfer occurs when ram_write_valid_o && ram_write_ready_i.
  - ram_write_valid_o and ram_write_data_o are held stable until the transfer.
  - A sample_valid_i arriving while the stage is occupied and not transferring in the same cycle is dropped; drop_count_o increments.
  - If a transfer and sample_valid_i coincide, the new sample is loaded and nothing is dropped.
- **Completion:** when sample_count_o reaches len, next state is DONE and ram_write_valid_o is low.
- **DONE:** done_o is held. start_i re-arms exactly as from IDLE.
- **ERROR:**
  - Entered when ram_overflow_i is high in ARMED or CAPTURE, or when a zero length is latched.
  - Any pending write is discarded. The state holds until start_i or abort_i.
  - start_i behaves as in IDLE.
- **abort_i:**
  - From any state, next state is IDLE and ram_write_valid_o is cleared.
  - Counters hold their value for inspection.
  - abort_i has priority over start_i and over overflow.
- **start_i in ARMED or CAPTURE** is ignored.

## Timing
- All outputs are registered.
- sample_valid_i at cycle t (trigger or capture) gives ram_write_valid_o high at t+1.
- The trigger sample appears on ram_write_data_o at t+1 and state_o is CAPTURE at t+1.
- sample_count_o increments in the cycle after each transfer.
- The final transfer at cycle t gives state DONE at t+1 and sample_count_o == len at t+1.
- start_i at t gives ARMED (or ERROR) at t+1.
- abort_i at t gives IDLE at t+1.
- ram_overflow_i at t gives ERROR at t+1.
- Throughput: one sample per cycle when ram_write_ready_i is held high.
- The I2S sample rate is far below this, so no drops occur with a ready RAM.

## Test plan
- **Immediate capture:** start with len=4 and mode 0, ready=1, then 6 valid strobes.
  - Exactly 4 writes occur, with data equal to the sign-extended samples.
  - DONE one cycle after the 4th transfer; sample_count=4, drop_count=0.
- **Threshold trigger:** threshold=0x100000, samples 0x000010, 0xF00000, 0x0FFFFF, -0x100000, then 2 more, with len=3.
  - Trigger fires on 0xF00000 (magnitude 0x100000).
  - Written data is 0xFFF00000, 0x000FFFFF, 0xFFF00000.
  - Samples 5–6 are ignored.
- **Backpressure:** ready=0 for 3 strobes in CAPTURE, with len=8.
  - First sample is held stable; drop_count=2.
  - When ready rises, the held sample transfers and sample_count=1.
  - Coincident transfer plus new strobe gives no drop.
- **Overflow and zero length:**
  - ram_overflow_i pulse mid-capture: ERROR next cycle, valid low, error_o=1.
  - start with len=0: ERROR next cycle.
- **Abort and priority:**
  - abort_i and start_i together in CAPTURE: IDLE, valid cleared, counts retained.
  - start_i in ARMED is ignored.
  - Reset asserted mid-capture: all outputs 0 next cycle.
